gl_fetch: RTL and testbench
===========================

Name: gl_fetch

Overview:
- Instruction fetch stage directly upstream of the GL command decoder.
- Walks a command program in instruction memory (synchronous read, 1-cycle latency) and splits each 32-bit word into opcode/type/imm.
- Holds each command stable for the decoder until the decoder's stall releases.
- Inserts a one-cycle NOP bubble between commands so every command is a fresh opcode change at the decoder.

Parameters:
- ADDR_W, 10, instruction memory word-address width.
- MIN_HOLD, 2, minimum cycles a command is presented before it may retire (covers the decoder's stall rise delay); legal range 1..15.
- NOP_OP, 8'h00, opcode driven during bubbles, idle and halt.
- HALT_OP, 8'hFF, opcode that ends the program.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins fetch at start_addr
- start_addr  in  ADDR_W  first instruction word address
- imem_addr  out  ADDR_W  instruction memory read address
- imem_en  out  1  read enable; data valid on imem_data the following cycle
- imem_data  in  32  instruction word: [31:24] opcode, [23] type, [22:0] imm
- opcode  out  8  to decoder
- type  out  1  to decoder
- imm  out  23  to decoder
- stall  in  1  decoder busy; command must be held while high
- busy  out  1  high from accepted start until HALT retires
- done  out  1  one-cycle pulse when HALT retires

Behaviour:
- Reset (async, rst_n low) values:
  - state=IDLE; opcode=NOP_OP, type=0, imm=0.
  - imem_addr=0, imem_en=0, busy=0, done=0; hold counter=0.
- All outputs are registered; decoder outputs change only on rising clk.
- IDLE:
  - start=1 -> imem_addr=start_addr, imem_en=1, busy=1, go to WAIT.
  - start while busy is ignored.
- WAIT (memory latency, one cycle):
  - Next edge: latch imem_data into opcode/type/imm, hold counter=MIN_HOLD-1, imem_en=0, go to PRESENT.
  - imem_addr increments by 1 at this same edge (prefetch address ready).
- PRESENT:
  - Command held while hold counter>0 (decrement each cycle) or stall=1.
  - Retires at the first edge with hold counter==0 and stall==0.
  - On retire, if opcode==HALT_OP: outputs -> NOP_OP/0/0, done=1 for one cycle, busy=0, go to IDLE.
  - On retire, otherwise: outputs -> NOP_OP/0/0, imem_en=1 (read of already-incremented imem_addr), go to BUBBLE.
- BUBBLE:
  - Exactly one cycle of NOP, during which the read completes.
  - Next edge behaves as WAIT's latch (load new word, reload counter, imem_en=0, imem_addr+1) -> PRESENT.
  - Steady state: one command per MIN_HOLD+1 cycles when stall stays low.
- stall is sampled only in PRESENT; stall high in IDLE/WAIT/BUBBLE has no effect.
- Address wrap: imem_addr is ADDR_W bits and wraps from all-ones to 0 without error.
- HALT at the last address: no prefetch issued.
- Reset mid-program: immediate return to IDLE reset values; no done pulse.
- start on the same edge HALT retires: ignored (busy still 1 at that edge); must be re-pulsed.
- Opcodes other than HALT_OP are passed through unmodified, including NOP_OP appearing in memory.

Optional Feature:
- GL_FETCH_TRACE_EN defined:
  - Adds output retired_count (32) and output last_pc (ADDR_W).
  - retired_count increments on every non-HALT retire; cleared by reset and by accepted start; saturates at 32'hFFFFFFFF.
  - last_pc holds the word address of the most recently retired command.
- Undefined: neither port exists and no counter logic is built.

Test Plan:
- Program at 0x010: {0x04 color, 0x10 matrixmode imm=1, 0xFF}, stall=0, MIN_HOLD=2.
  - Decoder sees 0x04 for 2 cycles, NOP 1 cycle, 0x10/imm=1 for 2 cycles, NOP, then done pulse.
  - busy high from start+1 until done; total 10 cycles start-to-done.
- Vertex 0x03 with stall raised 1 cycle after presentation and held 9 cycles.
  - opcode stays 0x03 until the first edge with stall low, then NOP.
  - Next address read only after that edge.
- Word 0x11_800005: type=1, imm=0x000005 exactly; 23-bit imm upper bits not sign-extended.
- start_addr=all-ones (ADDR_W=10, 0x3FF) holding 0x04, with 0x000 holding 0xFF.
  - Fetch wraps to 0x000; HALT executes; done=1.
- rst_n low while PRESENT with stall high.
  - Outputs go to NOP_OP, busy=0 immediately (asynchronous); no done.
  - A later start restarts cleanly at start_addr.
- GL_FETCH_TRACE_EN: 5 commands + HALT.
  - retired_count=5, last_pc=address of the 5th command.
  - A new start clears the count to 0.

Source files
------------

// File: rtl/gl_fetch.sv
// GL command fetch: walks instruction memory and presents opcode/type/imm to the decoder.
// Define GL_FETCH_TRACE_EN to add the retired_count / last_pc trace outputs.
module gl_fetch #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned MIN_HOLD = 2,
    parameter logic [7:0]  NOP_OP   = 8'h00,
    parameter logic [7:0]  HALT_OP  = 8'hFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_en,
    input  logic [31:0]       imem_data,
    output logic [7:0]        opcode,
    output logic              cmd_type,
    output logic [22:0]       imm,
    input  logic              stall,
    output logic              busy,
    output logic              done
`ifdef GL_FETCH_TRACE_EN
    ,
    output logic [31:0]       retired_count,
    output logic [ADDR_W-1:0] last_pc
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PRESENT, S_BUBBLE} state_t;

    localparam logic [3:0] HOLD_INIT = 4'(MIN_HOLD - 1);

    state_t     state;
    logic [3:0] hold_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            opcode    <= NOP_OP;
            cmd_type  <= 1'b0;
            imm       <= '0;
            imem_addr <= '0;
            imem_en   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        imem_addr <= start_addr;
                        imem_en   <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_WAIT;
                    end
                end
                // Bubble doubles as the read-latency cycle for the prefetched word.
                S_WAIT, S_BUBBLE: begin
                    opcode    <= imem_data[31:24];
                    cmd_type  <= imem_data[23];
                    imm       <= imem_data[22:0];
                    hold_cnt  <= HOLD_INIT;
                    imem_en   <= 1'b0;
                    imem_addr <= imem_addr + 1'b1;
                    state     <= S_PRESENT;
                end
                S_PRESENT: begin
                    if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end else if (!stall) begin
                        opcode   <= NOP_OP;
                        cmd_type <= 1'b0;
                        imm      <= '0;
                        if (opcode == HALT_OP) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            imem_en <= 1'b1;
                            state   <= S_BUBBLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef GL_FETCH_TRACE_EN
    logic retire_cmd;

    assign retire_cmd = (state == S_PRESENT) && (hold_cnt == '0) && !stall
                        && (opcode != HALT_OP);

    // imem_addr already points one past the presented word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_count <= '0;
            last_pc       <= '0;
        end else if (state == S_IDLE && start) begin
            retired_count <= '0;
        end else if (retire_cmd) begin
            last_pc <= imem_addr - 1'b1;
            if (retired_count != '1) begin
                retired_count <= retired_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gl_fetch.sv
// Directed self-checking bench for gl_fetch (default parameters, 1-cycle synchronous memory model).
module tb_gl_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [9:0]  start_addr;
    logic [9:0]  imem_addr;
    logic        imem_en;
    logic [31:0] imem_data = '0;
    logic [7:0]  opcode;
    logic        cmd_type;
    logic [22:0] imm;
    logic        stall;
    logic        busy;
    logic        done;
`ifdef GL_FETCH_TRACE_EN
    logic [31:0] retired_count;
    logic [9:0]  last_pc;
`endif

    logic [31:0] mem [0:1023];
    int unsigned total = 0;
    int unsigned bad   = 0;

    gl_fetch #(
        .ADDR_W  (10),
        .MIN_HOLD(2),
        .NOP_OP  (8'h00),
        .HALT_OP (8'hFF)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .start_addr   (start_addr),
        .imem_addr    (imem_addr),
        .imem_en      (imem_en),
        .imem_data    (imem_data),
        .opcode       (opcode),
        .cmd_type     (cmd_type),
        .imm          (imm),
        .stall        (stall),
        .busy         (busy),
        .done         (done)
`ifdef GL_FETCH_TRACE_EN
        ,
        .retired_count(retired_count),
        .last_pc      (last_pc)
`endif
    );

    always #5 clk = ~clk;

    // Read on the falling edge so data is valid at the next rising edge.
    always @(negedge clk) begin
        if (imem_en) imem_data <= mem[imem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, input int unsigned lim);
        int unsigned n = 0;
        while (done !== 1'b1 && n < lim) begin
            tick();
            n++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    logic [7:0] exp_op [10];

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        start_addr = '0;
        stall = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'hFF00_0000;
        mem[10'h010] = 32'h0400_0123;
        mem[10'h011] = 32'h1000_0001;
        mem[10'h020] = 32'h0300_0007;
        mem[10'h030] = 32'h1180_0005;
        mem[10'h040] = 32'h0300_0009;
        mem[10'h3FF] = 32'h0400_0000;
        for (int i = 0; i < 5; i++) mem[10'h050 + i] = {8'h20 + 8'(i), 24'(i)};

        tick();
        tick();
        check("rst_opcode", 32'(opcode), 32'h00);
        check("rst_type", 32'(cmd_type), 32'd0);
        check("rst_imm", 32'(imm), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_en", 32'(imem_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic program at 0x010; start pulses while busy and at HALT retire are ignored.
        exp_op = '{8'h04, 8'h04, 8'h00, 8'h10, 8'h10, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00};
        start = 1'b1;
        start_addr = 10'h010;
        tick();
        start = 1'b0;
        check("t1_start_busy", 32'(busy), 32'd1);
        check("t1_start_en", 32'(imem_en), 32'd1);
        check("t1_start_addr", 32'(imem_addr), 32'h010);
        check("t1_start_op", 32'(opcode), 32'h00);
        for (int c = 1; c <= 10; c++) begin
            start = (c == 2 || c == 9);
            start_addr = 10'h020;
            tick();
            start = 1'b0;
            check($sformatf("t1_op_c%0d", c), 32'(opcode), 32'(exp_op[c-1]));
            check($sformatf("t1_done_c%0d", c), 32'(done), 32'(c == 9));
            check($sformatf("t1_busy_c%0d", c), 32'(busy), 32'(c < 9));
            if (c == 1) begin
                check("t1_imm0", 32'(imm), 32'h123);
                check("t1_prefetch_addr", 32'(imem_addr), 32'h011);
                check("t1_en_off", 32'(imem_en), 32'd0);
            end
            if (c == 3) check("t1_bubble_en", 32'(imem_en), 32'd1);
            if (c == 4) check("t1_imm1", 32'(imm), 32'd1);
        end

        // Stall held over a vertex command; stall in BUBBLE has no effect.
        start = 1'b1;
        start_addr = 10'h020;
        tick();
        start = 1'b0;
        tick();
        check("t2_present", 32'(opcode), 32'h03);
        stall = 1'b1;
        for (int k = 2; k <= 10; k++) begin
            tick();
            check($sformatf("t2_hold_k%0d", k), 32'(opcode), 32'h03);
            check($sformatf("t2_noread_k%0d", k), 32'(imem_en), 32'd0);
        end
        stall = 1'b0;
        tick();
        check("t2_retire_op", 32'(opcode), 32'h00);
        check("t2_retire_en", 32'(imem_en), 32'd1);
        check("t2_retire_addr", 32'(imem_addr), 32'h021);
        stall = 1'b1;
        tick();
        check("t2_bubble_stall", 32'(opcode), 32'hFF);
        stall = 1'b0;
        wait_done("t2_done", 5);

        // Immediate field: type bit set, no sign extension.
        start = 1'b1;
        start_addr = 10'h030;
        tick();
        start = 1'b0;
        tick();
        check("t3_op", 32'(opcode), 32'h11);
        check("t3_type", 32'(cmd_type), 32'd1);
        check("t3_imm", 32'(imm), 32'h000005);
        wait_done("t3_done", 6);

        // Address wrap 0x3FF -> 0x000; stall during WAIT ignored.
        start = 1'b1;
        start_addr = 10'h3FF;
        stall = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("t4_op", 32'(opcode), 32'h04);
        check("t4_wrap_addr", 32'(imem_addr), 32'h000);
        stall = 1'b0;
        tick();
        tick();
        check("t4_retired", 32'(opcode), 32'h00);
        wait_done("t4_done", 6);

        // HALT at the last address: no prefetch.
        mem[10'h3FF] = 32'hFF00_0000;
        start = 1'b1;
        start_addr = 10'h3FF;
        tick();
        start = 1'b0;
        tick();
        check("t4b_op", 32'(opcode), 32'hFF);
        tick();
        tick();
        check("t4b_done", 32'(done), 32'd1);
        check("t4b_no_prefetch", 32'(imem_en), 32'd0);
        check("t4b_addr", 32'(imem_addr), 32'h000);

        // Asynchronous reset while PRESENT with stall high.
        start = 1'b1;
        start_addr = 10'h040;
        tick();
        start = 1'b0;
        tick();
        stall = 1'b1;
        tick();
        tick();
        check("t5_held", 32'(opcode), 32'h03);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_op", 32'(opcode), 32'h00);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_en", 32'(imem_en), 32'd0);
        check("t5_rst_addr", 32'(imem_addr), 32'h000);
        tick();
        check("t5_no_done", 32'(done), 32'd0);
        stall = 1'b0;
        rst_n = 1'b1;
        tick();
        start = 1'b1;
        start_addr = 10'h030;
        tick();
        start = 1'b0;
        check("t5_restart_addr", 32'(imem_addr), 32'h030);
        tick();
        check("t5_restart_op", 32'(opcode), 32'h11);
        wait_done("t5_done", 6);

`ifdef GL_FETCH_TRACE_EN
        start = 1'b1;
        start_addr = 10'h050;
        tick();
        start = 1'b0;
        wait_done("tr_done", 40);
        check("tr_count", retired_count, 32'd5);
        check("tr_last_pc", 32'(last_pc), 32'h054);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("tr_cleared", retired_count, 32'd0);
        wait_done("tr_done2", 40);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
